// File: rtl/frame_mux_sender_if.sv
// frame_mux_sender_if: TX packet stream from the frame packetiser to the Ethernet sender.
interface frame_mux_sender_if;
    logic [31:0] tx_data;
    logic        tx_vld;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_rdy;
    logic [15:0] udp_pkt_len;
    modport master (output tx_data, tx_vld, tx_sop, tx_eop, udp_pkt_len, input tx_rdy);
    modport slave  (input tx_data, tx_vld, tx_sop, tx_eop, udp_pkt_len, output tx_rdy);
endinterface

// File: rtl/frame_mux_sender.sv
// frame_mux_sender: round-robin N-channel frame packetiser onto a sop/eop TX stream.
// Define FRAME_SEQ_EN to send a per-channel 32-bit sequence word after the header.
module frame_mux_sender #(
    parameter int N_CH   = 4,
    parameter int SIZE_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        i_frame_ready,
    input  logic [N_CH*SIZE_W-1:0] i_frame_size,
    input  logic [N_CH*32-1:0]     i_in_data,
    input  logic [N_CH-1:0]        i_in_vld,
    output logic [N_CH-1:0]        o_in_rdy,
    output logic [15:0]            o_drop_cnt,
    frame_mux_sender_if.master     tx
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
`ifdef FRAME_SEQ_EN
    localparam int HDR_WORDS = 2;
    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;
`else
    localparam int HDR_WORDS = 1;
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif
    state_t            state;
    logic [N_CH-1:0]   pending, clr;
    logic [SIZE_W-1:0] size_q [N_CH];
    logic [SIZE_W-1:0] size_r, cnt;
    logic [CW-1:0]     ch, rr, nxt;
    logic [CW:0]       idx;
    logic              found, beat, last_word, hdr_last, done;
    logic [4:0]        drops;
    logic [16:0]       drop_sum;
    logic [31:0]       hdr, seq_word;

    // first pending channel after the last grant, scanning downwards so the nearest wins
    always_comb begin
        nxt = rr;
        found = 1'b0;
        idx = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = {1'b0, rr} + (CW+1)'(i);
            idx = idx >= (CW+1)'(N_CH) ? idx - (CW+1)'(N_CH) : idx;
            if (pending[idx[CW-1:0]]) begin
                nxt = idx[CW-1:0];
                found = 1'b1;
            end
        end
    end

`ifdef FRAME_SEQ_EN
    assign hdr_last = state == SEQ;
`else
    assign hdr_last = state == HDR;
`endif
    assign beat      = state == DATA && i_in_vld[ch] && tx.tx_rdy;
    assign last_word = cnt == size_r - SIZE_W'(1);
    assign done      = (beat && last_word) || (hdr_last && tx.tx_rdy && size_r == '0);
    assign clr       = done ? N_CH'(1) << ch : '0;
    assign hdr       = {8'hA5, 4'h0, 4'(ch), 2'b00, 14'(size_r)};

    always_comb begin
        tx.tx_vld  = state == DATA ? i_in_vld[ch] : state != IDLE;
        tx.tx_sop  = state == HDR;
        tx.tx_eop  = state == DATA ? i_in_vld[ch] && last_word : hdr_last && size_r == '0;
        tx.tx_data = state == DATA ? i_in_data[ch*32 +: 32] : state == HDR ? hdr : hdr_last ? seq_word : '0;
        o_in_rdy   = state == DATA ? N_CH'(tx.tx_rdy) << ch : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch <= '0;
            rr <= CW'(N_CH - 1);
            size_r <= '0;
            cnt <= '0;
            tx.udp_pkt_len <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= HDR;
                    ch <= nxt;
                    rr <= nxt;
                    size_r <= size_q[nxt];
                    cnt <= '0;
                    tx.udp_pkt_len <= 16'((32'(size_q[nxt]) + HDR_WORDS) << 2);
                end
`ifdef FRAME_SEQ_EN
                HDR: if (tx.tx_rdy) state <= SEQ;
                SEQ: if (tx.tx_rdy) state <= size_r == '0 ? IDLE : DATA;
`else
                HDR: if (tx.tx_rdy) state <= size_r == '0 ? IDLE : DATA;
`endif
                DATA: if (beat) begin
                    cnt <= cnt + 1'b1;
                    if (last_word) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a pulse on a channel whose frame is still outstanding is lost, unless it lands on the completing beat
    always_comb begin
        drops = '0;
        for (int k = 0; k < N_CH; k++)
            drops = drops + 5'(i_frame_ready[k] && pending[k] && !clr[k]);
    end
    assign drop_sum = 17'(o_drop_cnt) + 17'(drops);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            o_drop_cnt <= '0;
            for (int k = 0; k < N_CH; k++) size_q[k] <= '0;
        end else begin
            o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            for (int k = 0; k < N_CH; k++) begin
                if (i_frame_ready[k] && (!pending[k] || clr[k])) begin
                    pending[k] <= 1'b1;
                    size_q[k] <= i_frame_size[k*SIZE_W +: SIZE_W];
                end else if (clr[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

`ifdef FRAME_SEQ_EN
    logic [31:0] seq_cnt [N_CH];
    assign seq_word = seq_cnt[ch];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) seq_cnt[k] <= '0;
        end else if (done) begin
            seq_cnt[ch] <= seq_cnt[ch] + 32'd1;
        end
    end
`else
    assign seq_word = '0;
`endif
endmodule

// File: tb/tb_frame_mux_sender.sv
// tb_frame_mux_sender: scoreboard bench for frame_mux_sender; honours FRAME_SEQ_EN.
module tb_frame_mux_sender;
    localparam int N_CH = 4, SIZE_W = 14;
`ifdef FRAME_SEQ_EN
    localparam int HW = 2;
`else
    localparam int HW = 1;
`endif
    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] len;
    } beat_t;

    logic                   clk = 1'b0, rst = 1'b1;
    logic [N_CH-1:0]        i_frame_ready = '0, i_in_vld, o_in_rdy;
    logic [N_CH*SIZE_W-1:0] i_frame_size = '0;
    logic [N_CH*32-1:0]     i_in_data;
    logic [15:0]            o_drop_cnt;
    logic [15:0]            src_idx [N_CH] = '{default: 16'd0};
    beat_t                  q [$];
    beat_t                  e;
    int                     exp_base [N_CH] = '{default: 0};
    int                     exp_drop = 0, errors = 0, checks = 0, cyc = 0, last_eop = 0;
    bit                     stall = 1'b0, gap_chk = 1'b0, hold = 1'b0;
    logic [31:0]            hold_data = '0;
`ifdef FRAME_SEQ_EN
    logic [31:0]            exp_seq [N_CH] = '{default: 32'd0};
`endif

    frame_mux_sender_if tx();

    frame_mux_sender #(.N_CH(N_CH), .SIZE_W(SIZE_W)) dut (
        .clk(clk), .rst(rst), .i_frame_ready(i_frame_ready), .i_frame_size(i_frame_size),
        .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
        .o_drop_cnt(o_drop_cnt), .tx(tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N_CH; k++)
            if (!rst && i_in_vld[k] && o_in_rdy[k]) src_idx[k] <= src_idx[k] + 16'd1;
    end

    always_comb
        for (int k = 0; k < N_CH; k++) i_in_data[k*32 +: 32] = {4'hD, 4'(k), 8'h00, src_idx[k]};

    initial begin
        tx.tx_rdy = 1'b1;
        i_in_vld = '1;
        forever begin
            @(posedge clk);
            #1;
            tx.tx_rdy = stall ? $urandom_range(0, 2) != 0 : 1'b1;
            i_in_vld = stall ? N_CH'($urandom) : '1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int ch, input int sz);
        beat_t b;
        b.len = 16'((sz + HW) * 4);
        b.data = {8'hA5, 4'h0, 4'(ch), 2'b00, 14'(sz)};
        b.sop = 1'b1;
        b.eop = sz == 0 && HW == 1;
        q.push_back(b);
`ifdef FRAME_SEQ_EN
        b.data = exp_seq[ch];
        b.sop = 1'b0;
        b.eop = sz == 0;
        q.push_back(b);
        exp_seq[ch] = exp_seq[ch] + 32'd1;
`endif
        for (int i = 0; i < sz; i++) begin
            b.data = {4'hD, 4'(ch), 8'h00, 16'(exp_base[ch] + i)};
            b.sop = 1'b0;
            b.eop = i == sz - 1;
            q.push_back(b);
        end
        exp_base[ch] += sz;
    endtask

    task automatic arm(input int ch, input int sz, input bit acc);
        i_frame_ready[ch] = 1'b1;
        i_frame_size[ch*SIZE_W +: SIZE_W] = SIZE_W'(sz);
        if (acc) push_frame(ch, sz);
        else exp_drop++;
    endtask

    task automatic fire(input int ch, input int sz, input bit acc);
        @(posedge clk);
        #1;
        arm(ch, sz, acc);
        @(posedge clk);
        #1;
        i_frame_ready = '0;
    endtask

    task automatic wait_eop();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tx.tx_vld && tx.tx_eop && tx.tx_rdy) && n < 3000);
        if (n >= 3000) check("eop_timeout", n, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_qual"}, {tx.tx_vld, tx.tx_sop, tx.tx_eop}, 0);
        check({tag, "_data"}, tx.tx_data, 0);
        check({tag, "_in_rdy"}, o_in_rdy, 0);
        check({tag, "_len"}, tx.udp_pkt_len, 0);
        check({tag, "_drop"}, o_drop_cnt, 0);
    endtask

    // scoreboard: every accepted beat must match the front of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (hold) check("hdr_hold", {tx.tx_vld, tx.tx_sop, tx.tx_data}, {2'b11, hold_data});
            if (!tx.tx_vld) check("idle_qual", {tx.tx_sop, tx.tx_eop}, 2'b00);
            if (tx.tx_vld && tx.tx_rdy) begin
                if (q.size() == 0) begin
                    check("extra_beat", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("data", tx.tx_data, e.data);
                    check("sop_eop", {tx.tx_sop, tx.tx_eop}, {e.sop, e.eop});
                    check("pkt_len", tx.udp_pkt_len, e.len);
                    if (gap_chk && tx.tx_sop && last_eop != 0) check("gap", cyc - last_eop, 2);
                    if (tx.tx_eop) last_eop = cyc;
                end
            end
            hold = tx.tx_vld && !tx.tx_rdy && tx.tx_sop;
            hold_data = tx.tx_data;
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        int start, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // simultaneous ch0/ch3, then ch0 again: order ch0, ch3, ch0 with one idle cycle between
        gap_chk = 1'b1;
        @(posedge clk);
        #1;
        arm(0, 3, 1'b1);
        arm(3, 6, 1'b1);
        @(posedge clk);
        #1;
        i_frame_ready = '0;
        wait_eop();
        fire(0, 4, 1'b1);
        drain();
        gap_chk = 1'b0;

        // single frame with latency check: idle one cycle after the pulse edge, header the next
        fire(2, 3, 1'b1);
        @(negedge clk);
        check("lat_idle", tx.tx_vld, 1'b0);
        @(negedge clk);
        check("lat_hdr", {tx.tx_vld, tx.tx_sop, tx.tx_data}, {2'b11, 32'hA5020003});
        drain();

        stall = 1'b1;
        fire(2, 100, 1'b1);
        drain();
        stall = 1'b0;

        fire(1, 20, 1'b1);
        start = int'(src_idx[1]);
        n = 0;
        while (int'(src_idx[1]) < start + 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        fire(1, 7, 1'b0);
        @(negedge clk);
        check("drop_mid", o_drop_cnt, 16'(exp_drop));
        wait_eop();
        fire(1, 5, 1'b1);
        wait_eop();
        arm(1, 2, 1'b1);
        @(posedge clk);
        #1;
        i_frame_ready = '0;
        drain();
        check("drop_coincide", o_drop_cnt, 16'(exp_drop));

        fire(3, 0, 1'b1);
        drain();

        // reset while the 6th of 10 words is on the bus
        start = int'(src_idx[1]);
        fire(1, 10, 1'b1);
        n = 0;
        while (int'(src_idx[1]) != start + 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", int'(src_idx[1]) - start, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        for (int k = 0; k < N_CH; k++) exp_base[k] = int'(src_idx[k]);
`ifdef FRAME_SEQ_EN
        for (int k = 0; k < N_CH; k++) exp_seq[k] = '0;
`endif
        exp_drop = 0;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fire(1, 4, 1'b1);
        drain();
        check("drop_final", o_drop_cnt, 16'(exp_drop));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_mux_sender.md
# frame_mux_sender

Multi-channel frame packetiser between N independent acquisition frame sources and the Ethernet TX stream. Each source announces a finished frame with a one-cycle ready pulse and a word count. The block grants sources round-robin, emits a header followed by the frame payload as a single sop/eop-delimited packet, and presents the matching UDP payload length in bytes. It generalises the single-source frame-to-packet path to N_CH channels, and adds per-packet channel tagging, overrun counting and an optional sequence word.

## Interface
- N_CH, 4, number of frame sources (1..16)
- SIZE_W, 14, width of frame word count (≤14)
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_frame_ready  in  N_CH  per-channel one-cycle pulse: frame complete
- i_frame_size  in  N_CH*SIZE_W  per-channel payload length in 32-bit words; sampled on the pulse
- i_in_data  in  N_CH*32  per-channel payload data
- i_in_vld  in  N_CH  per-channel payload valid
- o_in_rdy  out  N_CH  per-channel payload ready
- o_tx_data  out  32  packet word
- o_tx_vld / o_tx_sop / o_tx_eop  out  1  stream qualifiers
- i_tx_rdy  in  1  downstream ready
- o_udp_pkt_len  out  16  packet length in bytes, stable from sop through eop
- o_drop_cnt  out  16  saturating count of frame pulses lost to overrun

## Operation
- Per channel: pending flag plus captured size. On i_frame_ready[k], pending[k] is set and size is captured. If pending[k] is already set and the frame is not yet fully sent, the new pulse is dropped: the held size is kept and o_drop_cnt increments, saturating at 16'hFFFF.
- Clearing pending[k] on the last payload word takes the same cycle as a new pulse on k: the set wins, and the new size is captured with no drop.
- HDR_WORDS = 1, or 2 with the sequence option.
- Header word 0 = {8'hA5, 4'h0, ch[3:0], 2'b00, size[13:0]}. Unused size bits are zero when SIZE_W < 14.
- FSM states: IDLE, HDR, SEQ (option only), DATA.
  - IDLE: if any channel is pending, select the first pending channel after the last granted one, round-robin with wrap N_CH-1 -> 0. Latch ch and size, then go to HDR.
  - HDR: o_tx_vld=1, o_tx_sop=1, data = header word 0. Advance on i_tx_rdy. If size==0 and there is no SEQ, o_tx_eop=1 and the next state is IDLE (pending cleared).
  - SEQ: data = 32-bit sequence count for the selected channel; eop only if size==0.
  - DATA: o_tx_data = i_in_data[ch]; o_tx_vld = i_in_vld[ch]; o_in_rdy[ch] = i_tx_rdy, and all other o_in_rdy bits are 0. A word counter counts accepted beats (vld&rdy). o_tx_eop=1 on word size-1. After that beat is accepted, clear pending[ch] and go to IDLE.
- o_udp_pkt_len = (size + HDR_WORDS) << 2. It is computed in 16 bits and latched on grant.
- o_tx_sop and o_tx_eop are meaningful only while o_tx_vld=1. Both are 0 whenever o_tx_vld=0.

## Timing
- Reset values: o_tx_vld=0, o_tx_sop=0, o_tx_eop=0, o_tx_data=0, o_in_rdy=0, o_udp_pkt_len=0, o_drop_cnt=0. All pending flags and sequence counters are cleared, and the round-robin pointer is set so that channel 0 is next.
- Latency: a pulse at cycle t registers pending at t+1, is granted (IDLE->HDR) at t+1, and the header is valid at t+2.
- The header is held with all qualifiers stable until i_tx_rdy is sampled high.
- DATA is a zero-latency combinational pass-through: no bubbles, full throughput while both sides are ready.
- There is one idle cycle in IDLE between consecutive packets.
- Reset asserted mid-packet aborts the packet. No eop is produced, and the next packet after reset starts with sop.
- The channel's source must hold its frame data until it is drained. The block issues no backpressure via i_frame_ready.

## Configuration
- FRAME_SEQ_EN defined:
  - SEQ state present, HDR_WORDS=2.
  - Per-channel 32-bit sequence counter is sent as the second word. It increments after each completed packet on that channel and wraps 32'hFFFFFFFF -> 0.
- Not defined:
  - No SEQ state or counters, HDR_WORDS=1.
  - o_udp_pkt_len = (size+1)*4.

## Test plan
- Single frame, ch2, size=3, i_tx_rdy=1: header 32'hA5020003 with sop, then 3 data words, eop on word 3. o_udp_pkt_len=16 (20 with FRAME_SEQ_EN); header is valid 2 cycles after the pulse.
- Pulses on ch0 and ch3 in the same cycle, then ch0 again after its packet: grant order ch0, ch3, ch0; exactly one idle cycle between packets.
- Random i_tx_rdy and i_in_vld stalls, size=100: all 100 words are delivered in order, with no duplicates and no drops; the header is held stable while stalled.
- Second pulse on ch1 mid-packet: o_drop_cnt=1 and the packet length is unchanged. A pulse coinciding with the last beat instead gives o_drop_cnt unchanged and a new packet sent.
- size=0 frame: a single header beat with both sop=1 and eop=1 (or header+SEQ with eop on SEQ); o_udp_pkt_len=4 (8 with FRAME_SEQ_EN).
- rst=1 during DATA word 5 of 10: all outputs are zero next cycle and pending is cleared. A new pulse then produces a clean packet, with the sequence word reset to 0 under FRAME_SEQ_EN.
